// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: registered EX-stage ALU with ALUOp/funct decode.
// An optional iterative shift-add unsigned multiplier (MULTU) with HI/LO
// registers and MFHI/MFLO reads is enabled by defining ALU_MULT_EN.
// When ALU_MULT_EN is not defined, busy/hi/lo are tied to 0 and in_ready is tied to 1.
module alu_exec_ctrl #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       funct,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [3:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             out_valid,
  output logic             err,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_SLL = 4'b1110;
  localparam logic [3:0] OP_SRL = 4'b1101;
  localparam logic [3:0] OP_INV = 4'b1111;
`ifdef ALU_MULT_EN
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_MFHI  = 4'b1001;
  localparam logic [3:0] OP_MFLO  = 4'b1010;
`endif

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state, next_state;
  logic             accept;
  logic             mul_last;
  logic [3:0]       dec_op;
  logic [WIDTH-1:0] dec_res;
  logic             dec_err;
  logic             dec_mul;

`ifdef ALU_MULT_EN
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_nxt;
  logic [WIDTH:0]     psum;
  logic [WIDTH-1:0]   mcand;
  logic [SHW-1:0]     cnt;
  logic [WIDTH-1:0]   hi_q, lo_q;

  assign busy     = (state == MUL);
  assign mul_last = (state == MUL) && (cnt == SHW'(WIDTH - 1));
  assign hi       = hi_q;
  assign lo       = lo_q;

  // One shift-add step: add the multiplicand into the upper half when the
  // current multiplier bit (prod[0]) is set, then shift the whole product right.
  always_comb begin
    psum     = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    prod_nxt = {psum, prod[WIDTH-1:1]};
  end
`else
  assign busy     = 1'b0;
  assign mul_last = 1'b0;
  assign hi       = '0;
  assign lo       = '0;
`endif

  assign in_ready = ~busy;
  assign accept   = in_valid & in_ready;
  assign zero     = (result == '0);

  // Decode ALUOp/funct to an op code and compute the single-cycle result.
  always_comb begin
    dec_op  = OP_INV;
    dec_res = '0;
    dec_err = 1'b0;
    dec_mul = 1'b0;
    case (ALUOp)
      2'b00: dec_op = OP_ADD;
      2'b01: dec_op = OP_SUB;
      2'b10: begin
        case (funct)
          6'd36:   dec_op = OP_AND;
          6'd37:   dec_op = OP_OR;
          6'd32:   dec_op = OP_ADD;
          6'd34:   dec_op = OP_SUB;
          6'd42:   dec_op = OP_SLT;
          6'd39:   dec_op = OP_NOR;
          6'd0:    dec_op = OP_SLL;
          6'd2:    dec_op = OP_SRL;
`ifdef ALU_MULT_EN
          6'd25:   dec_op = OP_MULTU;
          6'd16:   dec_op = OP_MFHI;
          6'd18:   dec_op = OP_MFLO;
`endif
          default: dec_op = OP_INV;
        endcase
      end
      default: dec_op = OP_INV;
    endcase
    case (dec_op)
      OP_AND:   dec_res = a & b;
      OP_OR:    dec_res = a | b;
      OP_ADD:   dec_res = a + b;
      OP_SUB:   dec_res = a - b;
      OP_SLT:   dec_res[0] = ($signed(a) < $signed(b));
      OP_NOR:   dec_res = ~(a | b);
      OP_SLL:   dec_res = b << shamt;
      OP_SRL:   dec_res = b >> shamt;
`ifdef ALU_MULT_EN
      OP_MULTU: dec_mul = 1'b1;
      OP_MFHI:  dec_res = hi_q;
      OP_MFLO:  dec_res = lo_q;
`endif
      default:  dec_err = 1'b1;
    endcase
  end

  // Next-state logic: a MULTU accept enters MUL, the last step returns to IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept && dec_mul) next_state = MUL;
      MUL:     if (mul_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Output register: single-cycle ops and MULTU completion both pulse out_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op        <= OP_INV;
      result    <= '0;
      err       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept && !dec_mul) begin
        op        <= dec_op;
        result    <= dec_res;
        err       <= dec_err;
        out_valid <= 1'b1;
      end
`ifdef ALU_MULT_EN
      else if (mul_last) begin
        op        <= OP_MULTU;
        result    <= prod_nxt[WIDTH-1:0];
        err       <= 1'b0;
        out_valid <= 1'b1;
      end
`endif
    end
  end

`ifdef ALU_MULT_EN
  // Multiplier datapath: the low half of prod initially holds the multiplier
  // and is consumed one bit per cycle while the product shifts in from the top.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod  <= '0;
      mcand <= '0;
      cnt   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else if (accept && dec_mul) begin
      prod  <= {{WIDTH{1'b0}}, b};
      mcand <= a;
      cnt   <= '0;
    end else if (state == MUL) begin
      prod <= prod_nxt;
      cnt  <= cnt + 1'b1;
      if (mul_last) begin
        hi_q <= prod_nxt[2*WIDTH-1:WIDTH];
        lo_q <= prod_nxt[WIDTH-1:0];
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb_alu_exec_ctrl: randomized and directed checks of alu_exec_ctrl (WIDTH=32)
// against a behavioural reference model. MULTU tests run when ALU_MULT_EN is defined.
module tb_alu_exec_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  ALUOp;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] a, b;
  logic [3:0]  op;
  logic [31:0] result;
  logic        zero, out_valid, err, busy;
  logic [31:0] hi, lo;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  logic [3:0]  exp_op;
  logic [31:0] exp_res;
  logic        exp_err;
  logic [31:0] m_hi, m_lo;

  logic [5:0] fl [11] = '{6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd39,
                          6'd0, 6'd2, 6'd25, 6'd16, 6'd18};

  alu_exec_ctrl #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(ALUOp), .funct(funct), .shamt(shamt), .a(a), .b(b),
    .op(op), .result(result), .zero(zero), .out_valid(out_valid),
    .err(err), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Behavioural model of one request.
  function automatic void ref_alu(input logic [1:0] aop, input logic [5:0] fn,
                                  input logic [4:0] sh, input logic [31:0] xa, xb,
                                  output logic [3:0] o, output logic [31:0] r,
                                  output logic e);
    o = 4'hF; r = 0; e = 1'b1;
    if (aop == 2'b00) begin o = 4'b0010; r = xa + xb; e = 0; end
    else if (aop == 2'b01) begin o = 4'b0110; r = xa - xb; e = 0; end
    else if (aop == 2'b10) begin
      e = 0;
      case (fn)
        6'd36: begin o = 4'b0000; r = xa & xb; end
        6'd37: begin o = 4'b0001; r = xa | xb; end
        6'd32: begin o = 4'b0010; r = xa + xb; end
        6'd34: begin o = 4'b0110; r = xa - xb; end
        6'd42: begin o = 4'b0111; r = (int'(xa) < int'(xb)) ? 32'd1 : 32'd0; end
        6'd39: begin o = 4'b1100; r = ~(xa | xb); end
        6'd0:  begin o = 4'b1110; r = xb * (32'd1 << sh); end
        6'd2:  begin o = 4'b1101; r = xb / (32'd1 << sh); end
`ifdef ALU_MULT_EN
        6'd16: begin o = 4'b1001; r = m_hi; end
        6'd18: begin o = 4'b1010; r = m_lo; end
`endif
        default: begin o = 4'hF; r = 0; e = 1; end
      endcase
    end
  endfunction

  task automatic model_reset();
    exp_op = 4'hF; exp_res = 0; exp_err = 0; m_hi = 0; m_lo = 0;
  endtask

  // One cycle of (optionally valid) single-cycle request, then check outputs.
  task automatic step(input logic v, input logic [1:0] aop, input logic [5:0] fn,
                      input logic [4:0] sh, input logic [31:0] xa, xb);
    logic [3:0]  o;
    logic [31:0] r;
    logic        e;
    in_valid = v; ALUOp = aop; funct = fn; shamt = sh; a = xa; b = xb;
    ref_alu(aop, fn, sh, xa, xb, o, r, e);
    @(posedge clk); #1;
    if (v) begin exp_op = o; exp_res = r; exp_err = e; end
    check("out_valid", out_valid, v);
    check("op", op, exp_op);
    check("result", result, exp_res);
    check("zero", zero, exp_res == 0);
    if (v) check("err", err, exp_err);
    check("in_ready", in_ready, 1);
  endtask

`ifdef ALU_MULT_EN
  task automatic mult_run(input logic [31:0] xa, xb);
    int k;
    logic [63:0] p;
    in_valid = 1; ALUOp = 2'b10; funct = 6'd25; shamt = 0; a = xa; b = xb;
    @(posedge clk); #1;
    check("mul_busy", busy, 1);
    check("mul_in_ready", in_ready, 0);
    check("mul_ov_early", out_valid, 0);
    // Held competing request that must be ignored while busy.
    funct = 6'd32; a = $urandom; b = $urandom;
    k = 0;
    while (!out_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check("mul_latency", k, 32);
    p = {32'b0, xa} * {32'b0, xb};
    m_hi = p[63:32]; m_lo = p[31:0];
    exp_op = 4'b1000; exp_res = m_lo; exp_err = 0;
    check("mul_hi", hi, m_hi);
    check("mul_lo", lo, m_lo);
    check("mul_result", result, m_lo);
    check("mul_op", op, 4'b1000);
    check("mul_err", err, 0);
    check("mul_done_ready", in_ready, 1);
  endtask
`endif

  initial begin
    logic       v;
    logic [1:0] aop;
    logic [5:0] fn;
    logic [31:0] xa, xb;
    int         ov_cnt;
    reset = 1; in_valid = 0; ALUOp = 0; funct = 0; shamt = 0; a = 0; b = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_op", op, 4'hF);
    check("rst_result", result, 0);
    check("rst_zero", zero, 1);
    check("rst_ov", out_valid, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 1);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    reset = 0;

    // Signed compare and subtract-to-zero
    step(1, 2'b10, 6'd42, 0, 32'hFFFFFFFF, 32'd1);
    check("slt_const", result, 1);
    check("slt_op", op, 4'b0111);
    step(1, 2'b10, 6'd34, 0, 32'd5, 32'd5);
    check("sub_zero", zero, 1);
    // Shifts
    step(1, 2'b10, 6'd0, 5'd4, 32'h12345678, 32'h0000000F);
    check("sll_const", result, 32'h000000F0);
    step(1, 2'b10, 6'd2, 5'd4, 32'h0, 32'h0000000F);
    check("srl_const", result, 0);
    // Invalid decodes
    step(1, 2'b10, 6'd51, 0, 32'd7, 32'd9);
    check("inv_err", err, 1);
    step(1, 2'b11, 6'd32, 0, 32'd7, 32'd9);
    check("aluop11_err", err, 1);
    step(0, 2'b00, 6'd0, 0, 32'd1, 32'd1);

    // Async reset mid-stream
    step(1, 2'b00, 6'd0, 0, 32'd3, 32'd4);
    #2 reset = 1;
    #1;
    check("arst_op", op, 4'hF);
    check("arst_ov", out_valid, 0);
    check("arst_result", result, 0);
    model_reset();
    @(posedge clk); #1;
    reset = 0;

    // Random single-cycle traffic with idle gaps
    for (int i = 0; i < 300; i++) begin
      v = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0, 1:    aop = 2'b00;
        2:       aop = 2'b01;
        9:       aop = 2'b11;
        default: aop = 2'b10;
      endcase
      if ($urandom_range(0, 4) == 0) fn = 6'($urandom);
      else fn = fl[$urandom_range(0, 10)];
`ifdef ALU_MULT_EN
      if (fn == 6'd25) fn = 6'd16;
`endif
      xa = $urandom;
      xb = ($urandom_range(0, 3) == 0) ? xa : $urandom;
      step(v, aop, fn, 5'($urandom), xa, xb);
    end

`ifdef ALU_MULT_EN
    mult_run(32'hFFFFFFFF, 32'd2);
    check("t5_hi", hi, 32'd1);
    check("t5_lo", lo, 32'hFFFFFFFE);
    step(1, 2'b10, 6'd16, 0, 0, 0);
    check("mfhi_const", result, 32'd1);
    step(1, 2'b10, 6'd18, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      mult_run($urandom, $urandom);
      step(1, 2'b10, 6'd16, 0, $urandom, $urandom);
      step(1, 2'b10, 6'd18, 0, $urandom, $urandom);
    end
    mult_run(32'd123456, 32'd654321);

    // Reset during a MULTU aborts it
    in_valid = 1; ALUOp = 2'b10; funct = 6'd25; a = $urandom; b = $urandom;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (9) @(posedge clk);
    #2 reset = 1;
    #1;
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", in_ready, 1);
    check("abort_ov", out_valid, 0);
    model_reset();
    @(posedge clk); #1;
    reset = 0;
    ov_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) ov_cnt++;
    end
    check("abort_no_ov", ov_cnt, 0);
    check("abort_hi_stay", hi, 0);
`else
    step(1, 2'b10, 6'd25, 0, 32'd3, 32'd5);
    check("multu_inv", err, 1);
    step(1, 2'b10, 6'd16, 0, 32'd3, 32'd5);
    check("nomul_busy", busy, 0);
    check("nomul_hi", hi, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
